// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 for the MIPS pipeline: SR, Cause, EPC, PRId and the Count/Compare timer.
// Arbitrates interrupts against synchronous exceptions beside the M stage and handles ERET.
module cp0_exc_ctrl #(
   parameter int          NUM_HWINT   = 6,
   parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL    = 32'h1406_1138,
   parameter bit          BOOT_INT_EN = 1'b1,
   parameter bit          TIMER_EN    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           rd_addr,
   output logic [31:0]          rd_data,
   input  logic                 wr_en,
   input  logic [4:0]           wr_addr,
   input  logic [31:0]          wr_data,
   input  logic [31:0]          pc,
   input  logic                 exc_req,
   input  logic [4:0]           exc_code,
   input  logic                 exc_bd,
   input  logic                 eret,
   input  logic [NUM_HWINT-1:0] hw_int,
   output logic                 take,
   output logic [31:0]          handler_pc,
   output logic [31:0]          epc_out
);

   localparam logic [4:0] REG_NONE    = 5'd0;
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   localparam logic [NUM_HWINT-1:0] IM_RESET = {NUM_HWINT{BOOT_INT_EN}};
   localparam logic                 IE_RESET = BOOT_INT_EN;

   logic [NUM_HWINT-1:0] im_q, im_d;
   logic                 ie_q, ie_d;
   logic                 exl_q, exl_d;
   logic                 bd_q, bd_d;
   logic                 ti_q, ti_d;
   logic [NUM_HWINT-1:0] ip_q, ip_d;
   logic [4:0]           code_q, code_d;
   logic [31:0]          epc_q, epc_d;
   logic [31:0]          count_q, count_d;
   logic [31:0]          compare_q, compare_d;

   logic [NUM_HWINT-1:0] pend_s;
   logic                 int_req_s;
   logic [4:0]           wr_sel_s;
   logic [31:0]          epc_entry_s;
   logic [31:0]          sr_s;
   logic [31:0]          cause_s;

   // Timer interrupt shares the top hardware line.
   always_comb begin
      pend_s              = hw_int;
      pend_s[NUM_HWINT-1] = hw_int[NUM_HWINT-1] | ti_q;
   end

   assign int_req_s   = (|(pend_s & im_q)) & ie_q & ~exl_q;
   assign take        = (int_req_s | exc_req) & ~rst;
   assign handler_pc  = EXC_VECTOR;
   assign epc_entry_s = exc_bd ? (pc - 32'd4) : pc;
   assign wr_sel_s    = wr_en ? wr_addr : REG_NONE;
   assign epc_out     = (wr_en && (wr_addr == REG_EPC)) ? {wr_data[31:2], 2'b00} : epc_q;

   // Next-state: entry overrides MTC0, which overrides ERET on the fields they share.
   always_comb begin
      im_d      = im_q;
      ie_d      = ie_q;
      exl_d     = exl_q;
      bd_d      = bd_q;
      code_d    = code_q;
      epc_d     = epc_q;
      compare_d = compare_q;
      ip_d      = pend_s;
      count_d   = TIMER_EN ? (count_q + 32'd1) : 32'd0;
      ti_d      = TIMER_EN ? (ti_q | (count_q == compare_q)) : 1'b0;

      if (take) begin
         exl_d  = 1'b1;
         code_d = int_req_s ? 5'd0 : exc_code;
         if (!exl_q) begin
            epc_d = {epc_entry_s[31:2], 2'b00};
            bd_d  = exc_bd;
         end else begin
            epc_d = epc_q;
            bd_d  = bd_q;
         end
      end else begin
         if (eret) begin
            exl_d = 1'b0;
         end else begin
            exl_d = exl_q;
         end
         case (wr_sel_s)
            REG_COUNT: begin
               count_d = TIMER_EN ? wr_data : 32'd0;
            end
            REG_COMPARE: begin
               compare_d = wr_data;
               ti_d      = 1'b0;
            end
            REG_SR: begin
               im_d  = wr_data[10 +: NUM_HWINT];
               exl_d = wr_data[1];
               ie_d  = wr_data[0];
            end
            REG_EPC: begin
               epc_d = {wr_data[31:2], 2'b00};
            end
            default: begin
               epc_d = epc_q;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         im_q      <= IM_RESET;
         ie_q      <= IE_RESET;
         exl_q     <= 1'b0;
         bd_q      <= 1'b0;
         ti_q      <= 1'b0;
         ip_q      <= '0;
         code_q    <= 5'd0;
         epc_q     <= 32'd0;
         count_q   <= 32'd0;
         compare_q <= 32'hFFFF_FFFF;
      end else begin
         im_q      <= im_d;
         ie_q      <= ie_d;
         exl_q     <= exl_d;
         bd_q      <= bd_d;
         ti_q      <= ti_d;
         ip_q      <= ip_d;
         code_q    <= code_d;
         epc_q     <= epc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
      end
   end

   // Architectural views of SR and Cause; unlisted bits read 0.
   always_comb begin
      sr_s                     = 32'd0;
      sr_s[10 +: NUM_HWINT]    = im_q;
      sr_s[1]                  = exl_q;
      sr_s[0]                  = ie_q;
      cause_s                  = 32'd0;
      cause_s[31]              = bd_q;
      cause_s[30]              = ti_q;
      cause_s[10 +: NUM_HWINT] = ip_q;
      cause_s[6:2]             = code_q;
   end

   // MFC0 read mux.
   always_comb begin
      case (rd_addr)
         REG_COUNT:   rd_data = count_q;
         REG_COMPARE: rd_data = compare_q;
         REG_SR:      rd_data = sr_s;
         REG_CAUSE:   rd_data = cause_s;
         REG_EPC:     rd_data = epc_q;
         REG_PRID:    rd_data = PRID_VAL;
         default:     rd_data = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed, table-driven bench for cp0_exc_ctrl with default parameters.
module tb_cp0_exc_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] pc;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic        exc_bd;
   logic        eret;
   logic [5:0]  hw_int;
   logic        take;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] pc;
      logic        er;
      logic [4:0]  ec;
      logic        bd;
      logic        eret;
      logic [5:0]  hw;
      logic [4:0]  ra;
      logic        take;
      logic [31:0] rd;
      logic        ce;
      logic [31:0] epc;
   } vec_t;

   vec_t vecs[$];

   cp0_exc_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .pc         (pc),
      .exc_req    (exc_req),
      .exc_code   (exc_code),
      .exc_bd     (exc_bd),
      .eret       (eret),
      .hw_int     (hw_int),
      .take       (take),
      .handler_pc (handler_pc),
      .epc_out    (epc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One cycle: rst we wa wd pc er ec bd eret hw ra | take rd chk_epc epc
   task automatic a(input logic [31:0] r, we, wa, wd, p, er, ec, bd, et, hw, ra,
                    tk, rd, ce, ep);
      vec_t v;
      v.rst = r[0];   v.we = we[0];  v.wa = wa[4:0]; v.wd = wd;     v.pc = p;
      v.er = er[0];   v.ec = ec[4:0]; v.bd = bd[0];  v.eret = et[0]; v.hw = hw[5:0];
      v.ra = ra[4:0]; v.take = tk[0]; v.rd = rd;     v.ce = ce[0];  v.epc = ep;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; pc = v.pc;
      exc_req = v.er; exc_code = v.ec; exc_bd = v.bd; eret = v.eret;
      hw_int = v.hw; rd_addr = v.ra;
   endtask

   initial begin
      vec_t idle;
      idle = '{default: '0};
      drive(idle);

      // Reset and reset-state reads.
      a(1,0, 0,0,         0,     0, 0,0,0,'h00, 0, 0,32'h0,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,12, 0,32'h0000FC01, 1,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h0,        1,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,11, 0,32'hFFFFFFFF, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,15, 0,32'h14061138, 0,0);
      // hw_int[2] interrupt entry.
      a(0,0, 0,0,         'h3000,0, 0,0,0,'h04,14, 1,32'h0,        1,0);
      a(0,0, 0,0,         'h3004,0, 0,0,0,'h04,13, 0,32'h00001000, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h04,12, 0,32'h0000FC03, 1,'h3000);
      a(0,0, 0,0,         0,     0, 0,0,0,'h04,14, 0,32'h00003000, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,1,'h00, 0, 0,32'h0,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,12, 0,32'h0000FC01, 0,0);
      // Interrupt beats a simultaneous exception; eret re-enables at once.
      a(0,0, 0,0,         'h3020,1,10,0,0,'h01, 0, 1,32'h0,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h01,13, 0,32'h00000400, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,1,'h01,12, 0,32'h0000FC03, 0,0);
      a(0,0, 0,0,         'h3030,0, 0,0,0,'h01,12, 1,32'h0000FC01, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,14, 0,32'h00003030, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,1,'h00, 0, 0,32'h0,        0,0);
      // Delay-slot exception with IE=0, then nested exception.
      a(0,1,12,'hFC00,    0,     0, 0,0,0,'h00,12, 0,32'h0000FC01, 0,0);
      a(0,0, 0,0,         'h3010,1,12,1,0,'h00,12, 1,32'h0000FC00, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h80000030, 1,'h300C);
      a(0,0, 0,0,         'h3040,1, 4,0,0,'h00,14, 1,32'h0000300C, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h80000010, 1,'h300C);
      a(0,0, 0,0,         0,     0, 0,0,1,'h00,12, 0,32'h0000FC02, 0,0);
      // Timer: Compare=5, Count=0.
      a(0,1,11,5,         0,     0, 0,0,0,'h00,12, 0,32'h0000FC00, 0,0);
      a(0,1, 9,0,         0,     0, 0,0,0,'h00,11, 0,32'h00000005, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00, 9, 0,32'h0,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00, 9, 0,32'h1,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h80000010, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00, 9, 0,32'h3,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00, 9, 0,32'h4,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00, 9, 0,32'h5,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'hC0000010, 0,0);
      a(0,1,12,'h8001,    0,     0, 0,0,0,'h00,13, 0,32'hC0008010, 0,0);
      a(0,0, 0,0,         'h3050,0, 0,0,0,'h00,12, 1,32'h00008001, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h40008000, 1,'h3050);
      a(0,1,11,'h100,     0,     0, 0,0,0,'h00,13, 0,32'h40008000, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h00008000, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h0,        0,0);
      // Count wrap, and Compare write beating a same-edge match.
      a(0,1, 9,'hFFFFFFFE,0,     0, 0,0,0,'h00, 0, 0,32'h0,        0,0);
      a(0,1,11,'hFFFFFFFF,0,     0, 0,0,0,'h00, 9, 0,32'hFFFFFFFE, 0,0);
      a(0,1,11,'hFFFFFFFF,0,     0, 0,0,0,'h00, 9, 0,32'hFFFFFFFF, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00, 9, 0,32'h0,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h0,        0,0);
      // MTC0 EPC with same-cycle eret.
      a(0,1,14,'h3107,    0,     0, 0,0,1,'h00,12, 0,32'h00008003, 1,'h3104);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,14, 0,32'h00003104, 1,'h3104);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,12, 0,32'h00008001, 0,0);
      // Entry cancels a same-cycle MTC0 SR write.
      a(0,1,12,0,         'h3060,0, 0,0,0,'h20,12, 1,32'h00008001, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,12, 0,32'h00008003, 1,'h3060);
      a(0,1,13,'hFFFFFFFF,0,     0, 0,0,0,'h00,13, 0,32'h0,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h0,        0,0);
      a(0,1,15,0,         0,     0, 0,0,0,'h00, 3, 0,32'h0,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,15, 0,32'h14061138, 0,0);
      // Reset inside the handler.
      a(1,0, 0,0,         0,     1, 4,0,0,'h20,12, 0,32'h00008003, 0,0);
      a(1,0, 0,0,         0,     1, 4,0,0,'h20,12, 0,32'h0000FC01, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,14, 0,32'h0,        1,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,11, 0,32'hFFFFFFFF, 0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,13, 0,32'h0,        0,0);
      a(0,0, 0,0,         0,     0, 0,0,0,'h00,12, 0,32'h0000FC01, 0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #2;
         check($sformatf("v%0d_take", i), {31'd0, take}, {31'd0, vecs[i].take});
         check($sformatf("v%0d_rd%0d", i, vecs[i].ra), rd_data, vecs[i].rd);
         if (vecs[i].ce) begin
            check($sformatf("v%0d_epc_out", i), epc_out, vecs[i].epc);
         end else begin
            n_chk = n_chk;
         end
      end

      // Hand sequence: EPC low bits masked on bypass and on commit; handler vector.
      @(negedge clk);
      drive(idle);
      wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'hFFFF_FFFF;
      #2;
      check("bypass_mask", epc_out, 32'hFFFF_FFFC);
      check("handler_pc", handler_pc, 32'h0000_4180);
      @(negedge clk);
      wr_addr = 5'd13; wr_data = 32'h1234_5678; rd_addr = 5'd14;
      #2;
      check("epc_commit", rd_data, 32'hFFFF_FFFC);
      check("epc_no_bypass", epc_out, 32'hFFFF_FFFC);
      @(negedge clk);
      drive(idle);
      rd_addr = 5'd13;
      #2;
      check("cause_ro", rd_data, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Parametrised coprocessor-0 for the MIPS pipeline.
- Owns SR, Cause, EPC, PRId, plus Count/Compare timer registers.
- Arbitrates hardware interrupts, the internal timer interrupt and synchronous exceptions reported by the pipeline. Sets EPC, Cause.BD and ExcCode on entry and returns via ERET.
- Sits beside the M stage: the pipeline flushes and redirects to `handler_pc` when `take` is high.

Parameters:
- NUM_HWINT, 6: external interrupt lines, 1..6. They map to SR.IM/Cause.IP bits [10 +: NUM_HWINT].
- EXC_VECTOR, 32'h0000_4180: handler entry address.
- PRID_VAL, 32'h1406_1138: read-only PRId value.
- BOOT_INT_EN, 1: 1 = reset SR to IM all ones, IE=1; 0 = IM=0, IE=0.
- TIMER_EN, 1: 0 = Count frozen at 0 and TI never set.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_addr  in  5  CP0 read register number (MFC0)
- rd_data  out  32  combinational read data
- wr_en  in  1  MTC0 write enable
- wr_addr  in  5  CP0 write register number
- wr_data  in  32  MTC0 data
- pc  in  32  PC of the M-stage instruction
- exc_req  in  1  synchronous exception present in M stage
- exc_code  in  5  ExcCode of that exception
- exc_bd  in  1  M-stage instruction is in a branch delay slot
- eret  in  1  ERET in M stage
- hw_int  in  NUM_HWINT  level-sensitive external interrupt lines
- take  out  1  combinational: exception/interrupt accepted this cycle
- handler_pc  out  32  constant EXC_VECTOR
- epc_out  out  32  EPC with MTC0 bypass, for ERET

Behaviour:
- Register map: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId. Other addresses read 0 and ignore writes.
- SR layout: IM [10 +: NUM_HWINT], EXL bit 1, IE bit 0. All other bits read 0.
- Cause layout: BD 31, TI 30, IP [10 +: NUM_HWINT], ExcCode [6:2]. Read-only to MTC0.
- EPC: bits [1:0] always read 0.
- Pending vector: pend = hw_int, with TI ORed into bit NUM_HWINT-1.
- int_req = |(pend & IM) & IE & ~EXL.
- take = (int_req | exc_req) & ~rst.
- Cause.IP is a registered copy of pend, updated every cycle.
- Reset values:
  - SR per BOOT_INT_EN, EXL=0.
  - Cause = 0, EPC = 0, Count = 0, Compare = 32'hFFFF_FFFF.
  - rd_data and take follow from these values.
- Update priority at a clock edge, highest first: rst > entry (take) > MTC0 write > eret.
- Entry, interrupt vs exception:
  - Interrupt wins over a simultaneous exc_req: ExcCode = 0 (Int).
  - Otherwise ExcCode = exc_code.
- Entry, EPC:
  - If EXL was 0: EPC = exc_bd ? pc-4 : pc, BD = exc_bd.
  - If EXL was 1 (nested sync exception): EPC and BD unchanged, ExcCode still updated.
  - EXL then set to 1.
- Entry cancels a same-cycle MTC0 write and a same-cycle eret; the faulting instruction does not commit.
- eret: clears EXL at the edge. int_req may assert on the very next cycle.
- epc_out = (wr_en && wr_addr==14) ? {wr_data[31:2],2'b00} : EPC. This lets an ERET follow an MTC0 EPC with no stall.
- Count:
  - Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - An MTC0 write to Count loads wr_data instead of incrementing that cycle.
- TI:
  - Set at the edge where registered Count == Compare.
  - Cleared only by an MTC0 write to Compare. That write wins over a same-cycle match.
  - Holds until cleared, including across entry.
- MTC0 to SR writes IM, EXL, IE only. Writes to Cause and PRId are ignored.
- Reset asserted mid-handler: all state returns to reset values next edge and take is low during rst.

Test Plan:
- Reset, BOOT_INT_EN=1; hw_int=6'b000100, pc=32'h3000 -> take=1 same cycle. Next cycle: EPC=32'h3000, SR.EXL=1, Cause.ExcCode=0, Cause.IP[12]=1, take=0 while the line stays high.
- Same-cycle exc_req=1 (exc_code=5'd10) plus hw_int[0]=1 -> ExcCode=0. Then eret -> EXL=0 and take re-asserts next cycle while hw_int[0] is held.
- exc_req=1, exc_bd=1, pc=32'h3010, exc_code=5'd12 with IE=0 -> EPC=32'h300C, BD=1, ExcCode=12. A second exc_req while EXL=1 leaves EPC at 32'h300C.
- MTC0 Compare=5, Count=0 -> TI=1 at the edge after Count reads 5. Interrupt taken via bit NUM_HWINT-1. MTC0 Compare -> TI=0. Count=32'hFFFF_FFFF rolls to 0.
- MTC0 EPC=32'h3104 with eret in the same cycle -> epc_out=32'h3104 that cycle.
- Same-cycle MTC0 SR=0 and hw_int interrupt -> entry wins, SR.IM unchanged.
- Assert rst while EXL=1 -> all registers at reset values next cycle and take=0 throughout.
